// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between a host writer, the uart_tx_fifo buffer and the UART transmitter.
// The ovf_o flag exists only when UART_TX_FIFO_OVF_EN is defined.
interface uart_tx_fifo_if #(
    parameter int DataWidth = 8,
    parameter int AddrWidth = 4
);
    logic                 wr_en_i;
    logic [DataWidth-1:0] wr_data_i;
    logic                 full_o;
    logic                 empty_o;
    logic [AddrWidth:0]   count_o;
    logic                 tx_busy_o;
    logic [DataWidth-1:0] din_o;
    logic                 start_tx_o;
    logic                 tx_done_tick_i;
`ifdef UART_TX_FIFO_OVF_EN
    logic                 ovf_o;

    modport master (
        output wr_en_i, wr_data_i, tx_done_tick_i,
        input  full_o, empty_o, count_o, tx_busy_o, din_o, start_tx_o, ovf_o
    );
    modport slave (
        input  wr_en_i, wr_data_i, tx_done_tick_i,
        output full_o, empty_o, count_o, tx_busy_o, din_o, start_tx_o, ovf_o
    );
`else
    modport master (
        output wr_en_i, wr_data_i, tx_done_tick_i,
        input  full_o, empty_o, count_o, tx_busy_o, din_o, start_tx_o
    );
    modport slave (
        input  wr_en_i, wr_data_i, tx_done_tick_i,
        output full_o, empty_o, count_o, tx_busy_o, din_o, start_tx_o
    );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART transmitter one byte per done tick.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
    parameter int DataWidth = 8,
    parameter int AddrWidth = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    uart_tx_fifo_if.slave bus
);
    localparam int Depth = 2 ** AddrWidth;
    localparam logic [AddrWidth:0] FullCount = {1'b1, {AddrWidth{1'b0}}};

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;

    logic [DataWidth-1:0] mem [Depth];
    logic [AddrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrWidth:0]   count_q, count_d;
    logic                 full_q, empty_q;
    logic [1:0]           state_q, state_d;
    logic [DataWidth-1:0] din_q;
    logic                 wr_acc;
    logic                 pop;

    // Both handshakes use the registered flags, so a pop never frees room for a same-edge write.
    assign wr_acc = bus.wr_en_i & ~full_q;
    assign pop    = (state_q == StIdle) & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (!empty_q) state_d = StStart;
            StStart: state_d = StWait;
            StWait:  if (bus.tx_done_tick_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            state_q  <= StIdle;
            din_q    <= '0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == FullCount);
            empty_q <= (count_d == '0);
            state_q <= state_d;
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                din_q    <= mem[rd_ptr_q];
            end
        end
    end

    // Storage has no reset so it maps onto block RAM; the load into din_q is its registered read.
    always_ff @(posedge clk_i) begin
        if (wr_acc) mem[wr_ptr_q] <= bus.wr_data_i;
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (bus.wr_en_i && full_q) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf_o = ovf_q;
`endif

    assign bus.full_o     = full_q;
    assign bus.empty_o    = empty_q;
    assign bus.count_o    = count_q;
    assign bus.tx_busy_o  = (state_q != StIdle);
    assign bus.start_tx_o = (state_q == StStart);
    assign bus.din_o      = din_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model plus directed literal checks.
module tb_uart_tx_fifo;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

    uart_tx_fifo #(.DataWidth(DW), .AddrWidth(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Reference: a byte queue, plus whether a byte is in flight and whether its start cycle is now.
    logic [7:0] mq[$];
    bit         m_busy;
    bit         m_start;
    logic [7:0] m_din;
    bit         m_ovf;

    always @(posedge clk or posedge rst) begin
        int n;
        bit do_pop;
        bit acc;
        if (rst) begin
            mq.delete();
            m_busy  = 0;
            m_start = 0;
            m_din   = 8'h00;
            m_ovf   = 0;
        end else begin
            n      = mq.size();
            do_pop = !m_busy && (n > 0);
            acc    = bus.wr_en_i && (n < DEPTH);
            if (bus.wr_en_i && n >= DEPTH) m_ovf = 1;
            if (do_pop) begin
                m_din   = mq.pop_front();
                m_busy  = 1;
                m_start = 1;
            end else if (m_start) begin
                m_start = 0;
            end else if (m_busy && bus.tx_done_tick_i) begin
                m_busy = 0;
            end
            if (acc) mq.push_back(bus.wr_data_i);
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("count", 32'(bus.count_o), mq.size());
        check("empty", 32'(bus.empty_o), mq.size() == 0);
        check("full", 32'(bus.full_o), mq.size() == DEPTH);
        check("busy", 32'(bus.tx_busy_o), 32'(m_busy));
        check("start", 32'(bus.start_tx_o), 32'(m_start));
        check("din", 32'(bus.din_o), 32'(m_din));
`ifdef UART_TX_FIFO_OVF_EN
        check("ovf", 32'(bus.ovf_o), 32'(m_ovf));
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        bus.wr_en_i        = 1'b0;
        bus.wr_data_i      = 8'h00;
        bus.tx_done_tick_i = 1'b0;
    endtask

    // Tick the transmitter whenever a byte is waiting, until the DUT is idle and empty.
    task automatic drain();
        int c;
        for (c = 0; c < 400; c++) begin
            if (!bus.tx_busy_o && bus.empty_o) break;
            bus.tx_done_tick_i = bus.tx_busy_o && !bus.start_tx_o;
            cyc();
            bus.tx_done_tick_i = 1'b0;
        end
        check("drain_timeout", c < 400, 1);
    endtask

    initial begin
        int got_n;
        int tick_c;
        int c;
        idle_inputs();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        check("rst_count", 32'(bus.count_o), 0);
        check("rst_empty", 32'(bus.empty_o), 1);
        check("rst_full", 32'(bus.full_o), 0);
        check("rst_start", 32'(bus.start_tx_o), 0);
        check("rst_busy", 32'(bus.tx_busy_o), 0);
        check("rst_din", 32'(bus.din_o), 0);

        // Reset in the middle of a WAIT discards queued data and aborts the byte.
        bus.wr_en_i = 1'b1; bus.wr_data_i = 8'h11; cyc();
        bus.wr_data_i = 8'h22; cyc();
        bus.wr_en_i = 1'b0; cyc(); cyc();
        check("pre_rst_busy", 32'(bus.tx_busy_o), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_count", 32'(bus.count_o), 0);
        check("arst_busy", 32'(bus.tx_busy_o), 0);
        check("arst_din", 32'(bus.din_o), 0);
        check("arst_empty", 32'(bus.empty_o), 1);
        cyc();
        rst = 1'b0;
        bus.wr_en_i = 1'b1; bus.wr_data_i = 8'h33; cyc();
        bus.wr_en_i = 1'b0; cyc();
        check("post_rst_start", 32'(bus.start_tx_o), 1);
        check("post_rst_din", 32'(bus.din_o), 8'h33);
        drain();

        // Single byte latency.
        bus.wr_en_i = 1'b1; bus.wr_data_i = 8'hA5; cyc();
        bus.wr_en_i = 1'b0;
        check("single_E_empty", 32'(bus.empty_o), 0);
        check("single_E_start", 32'(bus.start_tx_o), 0);
        cyc();
        check("single_E1_start", 32'(bus.start_tx_o), 1);
        check("single_E1_din", 32'(bus.din_o), 8'hA5);
        check("single_E1_busy", 32'(bus.tx_busy_o), 1);
        cyc();
        check("single_E2_start", 32'(bus.start_tx_o), 0);
        check("single_E2_busy", 32'(bus.tx_busy_o), 1);
        cyc();
        bus.tx_done_tick_i = 1'b1; cyc(); bus.tx_done_tick_i = 1'b0;
        check("single_done_busy", 32'(bus.tx_busy_o), 0);

        // Spurious done tick in IDLE.
        bus.tx_done_tick_i = 1'b1; cyc(); bus.tx_done_tick_i = 1'b0;
        check("spur_start", 32'(bus.start_tx_o), 0);
        check("spur_busy", 32'(bus.tx_busy_o), 0);
        cyc();
        check("spur_start2", 32'(bus.start_tx_o), 0);

        // Burst of five with a done tick three cycles after every start.
        got_n = 0;
        tick_c = -10;
        for (c = 0; c < 200; c++) begin
            if (got_n == 5 && c > tick_c) break;
            bus.wr_en_i        = (c < 5);
            bus.wr_data_i      = 8'(c + 1);
            bus.tx_done_tick_i = (c == tick_c);
            cyc();
            if (bus.start_tx_o) begin
                check("burst_din", 32'(bus.din_o), got_n + 1);
                got_n++;
                tick_c = c + 3;
            end
        end
        idle_inputs();
        check("burst_pulses", got_n, 5);
        check("burst_empty", 32'(bus.empty_o), 1);
        check("burst_busy", 32'(bus.tx_busy_o), 0);

        // Fill without done ticks: 19 writes, one popped, 16 stored, 2 dropped.
        for (int i = 0; i < 19; i++) begin
            bus.wr_en_i = 1'b1; bus.wr_data_i = 8'(8'h40 + i); cyc();
        end
        bus.wr_en_i = 1'b0;
        check("fill_count", 32'(bus.count_o), 16);
        check("fill_full", 32'(bus.full_o), 1);
        check("fill_din", 32'(bus.din_o), 8'h40);
`ifdef UART_TX_FIFO_OVF_EN
        check("fill_ovf", 32'(bus.ovf_o), 1);
`endif

        // Write in the same cycle as a pop while full: write dropped.
        bus.tx_done_tick_i = 1'b1; cyc(); bus.tx_done_tick_i = 1'b0;
        bus.wr_en_i = 1'b1; bus.wr_data_i = 8'hEE; cyc(); bus.wr_en_i = 1'b0;
        check("fullpop_count", 32'(bus.count_o), 15);
        check("fullpop_start", 32'(bus.start_tx_o), 1);
        check("fullpop_din", 32'(bus.din_o), 8'h41);

        // Drain to three entries while in WAIT, then write plus pop.
        for (c = 0; c < 400; c++) begin
            if (bus.count_o == 3 && bus.tx_busy_o && !bus.start_tx_o) break;
            bus.tx_done_tick_i = bus.tx_busy_o && !bus.start_tx_o;
            cyc();
            bus.tx_done_tick_i = 1'b0;
        end
        check("reach3_timeout", c < 400, 1);
        bus.tx_done_tick_i = 1'b1; cyc(); bus.tx_done_tick_i = 1'b0;
        bus.wr_en_i = 1'b1; bus.wr_data_i = 8'h77; cyc(); bus.wr_en_i = 1'b0;
        check("wp3_count", 32'(bus.count_o), 3);
        check("wp3_start", 32'(bus.start_tx_o), 1);
        drain();

        // Randomised traffic with rare asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            bus.wr_en_i        = ($urandom_range(0, 99) < 55);
            bus.wr_data_i      = 8'($urandom);
            bus.tx_done_tick_i = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 999) == 0) begin
                #2 rst = 1'b1;
                #1;
                check("rand_arst_count", 32'(bus.count_o), 0);
                cyc();
                rst = 1'b0;
            end else begin
                cyc();
            end
        end
        idle_inputs();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
